main_memory_responder: RTL and testbench

- Responder end of the CPU memory bus: services line-sized read/write requests issued by the memory management unit.
- Backed by a byte-addressed storage array with configurable fixed access latency.
- Used as the system-level memory in simulation and FPGA top levels, sitting outside the cpu module.
- One outstanding request at a time; whole-line transfers only.

---
 rtl/main_memory_responder_pkg.sv | 31 +++
 rtl/main_memory_responder_if.sv | 37 +++
 rtl/main_memory_responder_memory_array.sv | 47 ++++
 rtl/main_memory_responder.sv | 144 ++++++++++++++
 tb/tb_main_memory_responder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/main_memory_responder_pkg.sv
// Shared types and sizing for the main memory responder.
//
// Contents:
//   XLEN                     - architectural word width the bus is sized from
//   BUS_WIDTH_BYTES_DEFAULT  - default line width (four XLEN words)
//   mem_state_e              - responder FSM states (IDLE / WAIT / DONE)
//   mem_op_e                 - latched request kind (MEM_READ / MEM_WRITE)
//   line_align()             - clears the in-line byte offset of an address
package memory_types;

  localparam int XLEN                    = 32;
  localparam int BUS_WIDTH_BYTES_DEFAULT = 4 * (XLEN / 8);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_state_e;

  typedef enum logic {
    MEM_READ,
    MEM_WRITE
  } mem_op_e;

  // bus_bytes is a power of two, so the mask removes exactly the offset bits.
  function automatic logic [31:0] line_align(input logic [31:0] address,
                                             input int unsigned bus_bytes);
    return address & ~(bus_bytes - 1);
  endfunction

endpackage

// File: rtl/main_memory_responder_if.sv
// CPU memory bus between the memory management unit (master) and the main
// memory responder (slave).
//
// Signals:
//   read, write  - request levels, sampled by the responder only while ready=1
//   address      - byte address of the line
//   data_in      - write line, little-endian (byte 0 = bits 7:0)
//   data_out     - read line, valid in the done cycle and held until next accept
//   ready        - responder idle and accepting
//   done         - single-cycle completion pulse
//   error        - only when MEM_RANGE_CHECK_EN is defined: out-of-range access,
//                  asserted together with done
interface main_memory_responder_if
  #(parameter int BUS_WIDTH_BYTES = memory_types::BUS_WIDTH_BYTES_DEFAULT);

  logic                         read;
  logic                         write;
  logic [31:0]                  address;
  logic [BUS_WIDTH_BYTES*8-1:0] data_in;
  logic [BUS_WIDTH_BYTES*8-1:0] data_out;
  logic                         ready;
  logic                         done;
`ifdef MEM_RANGE_CHECK_EN
  logic                         error;

  modport master (output read, write, address, data_in,
                  input  data_out, ready, done, error);
  modport slave  (input  read, write, address, data_in,
                  output data_out, ready, done, error);
`else
  modport master (output read, write, address, data_in,
                  input  data_out, ready, done);
  modport slave  (input  read, write, address, data_in,
                  output data_out, ready, done);
`endif

endinterface

// File: rtl/main_memory_responder_memory_array.sv
// memory_array: line-organised byte storage for the main memory responder.
// Line n holds bytes n*WIDTH_BYTES .. n*WIDTH_BYTES+WIDTH_BYTES-1, little-endian.
//
// Ports:
//   clock     - rising-edge clock
//   reset     - synchronous active-high; clears only the read register
//   wr_en     - write wr_data into line `index` at this edge
//   rd_en     - load line `index` into rd_data at this edge
//   rd_clear  - load zero into rd_data at this edge (rejected access)
//   index     - line index
//   wr_data   - line to store
//   rd_data   - registered read line, holds its value between loads
module memory_array #(
  parameter int WIDTH_BYTES = 16,
  parameter int DEPTH_BYTES = 65536,
  localparam int LINES      = DEPTH_BYTES / WIDTH_BYTES,
  localparam int INDEX_W    = $clog2(LINES)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     rd_clear,
  input  logic [INDEX_W-1:0]       index,
  input  logic [WIDTH_BYTES*8-1:0] wr_data,
  output logic [WIDTH_BYTES*8-1:0] rd_data
);

  logic [WIDTH_BYTES*8-1:0] storage [LINES];

  // NOTE: the storage array has no reset branch on purpose: contents survive
  // reset, and a reset loop over every line would stop it mapping to RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      storage[index] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || rd_clear) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= storage[index];
    end
  end

endmodule

// File: rtl/main_memory_responder.sv
// main_memory_responder: responder end of the CPU memory bus. Services one
// whole-line read or write at a time with a fixed access latency.
//
// Timeline for a request sampled at edge E0 (IDLE, read or write high):
//   E0 .. E(LATENCY-1)  WAIT, ready=0
//   E(LATENCY)          storage access happens, done=1 (and data_out valid)
//   E(LATENCY+1)        back to IDLE, ready=1
// so a request occupies LATENCY+2 cycles including the IDLE cycle.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-high; aborts any request, no done pulse
//   bus    - main_memory_responder_if slave modport
//
// Configuration:
//   MEM_RANGE_CHECK_EN - when defined, addresses >= DEPTH_BYTES are rejected
//                        (no write, data_out=0, error=1 with done); when not
//                        defined, addresses wrap modulo DEPTH_BYTES.
module main_memory_responder
  import memory_types::*;
#(
  parameter int BUS_WIDTH_BYTES = BUS_WIDTH_BYTES_DEFAULT,
  parameter int DEPTH_BYTES     = 65536,
  parameter int LATENCY         = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  main_memory_responder_if.slave  bus
);

  localparam int LINE_BITS  = $clog2(BUS_WIDTH_BYTES);
  localparam int INDEX_W    = $clog2(DEPTH_BYTES / BUS_WIDTH_BYTES);
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LINE_W     = BUS_WIDTH_BYTES * 8;

  mem_state_e         state;
  mem_op_e            op;
  logic [CNT_W-1:0]   count;
  logic [31:0]        addr_q;
  logic [LINE_W-1:0]  data_q;
  logic               ready_q;
  logic               done_q;

  logic               finishing;
  logic               out_of_range;
  logic [INDEX_W-1:0] line_index;
  logic               wr_en;
  logic               rd_en;
  logic               rd_clear;

  // Last WAIT cycle: the storage access and the done pulse take effect at
  // the coming edge.
  assign finishing = (state == WAIT) && (count == '0);

`ifdef MEM_RANGE_CHECK_EN
  logic error_q;
  assign out_of_range = (addr_q >= 32'(DEPTH_BYTES));
  assign bus.error    = error_q;
`else
  assign out_of_range = 1'b0;
`endif

  // Modulo by the power-of-two depth gives the wrap; in the range-checked
  // build out-of-range accesses never reach the storage anyway.
  assign line_index = INDEX_W'((addr_q % 32'(DEPTH_BYTES)) >> LINE_BITS);

  // A reset on the completing edge must discard the pending write.
  assign wr_en    = finishing && (op == MEM_WRITE) && !out_of_range && !reset;
  assign rd_en    = finishing && (op == MEM_READ)  && !out_of_range && !reset;
  assign rd_clear = finishing && out_of_range && !reset;

  memory_array #(
    .WIDTH_BYTES (BUS_WIDTH_BYTES),
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_memory_array (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rd_clear (rd_clear),
    .index    (line_index),
    .wr_data  (data_q),
    .rd_data  (bus.data_out)
  );

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later lines see new ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      op      <= MEM_READ;
      count   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
      error_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.read || bus.write) begin
            // Read wins when both are raised; the write is simply dropped.
            op      <= bus.read ? MEM_READ : MEM_WRITE;
            addr_q  <= line_align(bus.address, BUS_WIDTH_BYTES);
            data_q  <= bus.data_in;
            count   <= CNT_W'(LATENCY - 1);
            ready_q <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (count == '0) begin
            done_q  <= 1'b1;
`ifdef MEM_RANGE_CHECK_EN
            error_q <= out_of_range;
`endif
            state   <= DONE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
          error_q <= 1'b0;
`endif
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder (default parameters).
// A transaction-level model (cycle numbers, an associative line store) runs
// beside the DUT; a negedge process compares ready/done/data_out (and error
// with MEM_RANGE_CHECK_EN) every cycle. Directed cases pin the model with
// literal expectations, then a randomized phase exercises mixed traffic.
module tb_main_memory_responder;
  import memory_types::*;

  localparam int W     = 16;
  localparam int DEPTH = 65536;
  localparam int LAT   = 4;
  localparam int DW    = W * 8;

  localparam logic [DW-1:0] LINE_A = 128'h00112233445566778899AABBCCDDEEFF;

  logic clock = 1'b0;
  logic reset = 1'b1;

  main_memory_responder_if #(.BUS_WIDTH_BYTES(W)) bus ();

  main_memory_responder #(
    .BUS_WIDTH_BYTES (W),
    .DEPTH_BYTES     (DEPTH),
    .LATENCY         (LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no response within cycle budget (t=%0t)", name, $time);
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  logic [DW-1:0] model_mem [int unsigned];
  bit            m_ready = 1'b1;
  bit            m_done  = 1'b0;
  bit            m_err   = 1'b0;
  bit            m_known = 1'b1;
  logic [DW-1:0] m_data  = '0;
  bit            busy    = 1'b0;
  bit            started = 1'b0;
  int            cyc     = 0;
  int            finish_cyc = 0;
  bit            q_read;
  logic [31:0]   q_addr;
  logic [DW-1:0] q_data;

  always @(posedge clock) begin
    int unsigned line;
    cyc++;
    if (reset) begin
      busy    = 1'b0;
      m_ready = 1'b1;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_data  = '0;
      m_known = 1'b1;
      started = 1'b1;
    end else if (busy && cyc == finish_cyc + 1) begin
      busy    = 1'b0;
      m_ready = 1'b1;
      m_done  = 1'b0;
      m_err   = 1'b0;
    end else if (busy && cyc == finish_cyc) begin
      m_done = 1'b1;
      line   = (q_addr % DEPTH) / W;
`ifdef MEM_RANGE_CHECK_EN
      if (q_addr >= DEPTH) begin
        m_err   = 1'b1;
        m_data  = '0;
        m_known = 1'b1;
      end else
`endif
      if (q_read) begin
        if (model_mem.exists(line)) begin
          m_data  = model_mem[line];
          m_known = 1'b1;
        end else begin
          m_known = 1'b0;
        end
      end else begin
        model_mem[line] = q_data;
      end
    end else if (!busy && (bus.read || bus.write)) begin
      busy       = 1'b1;
      finish_cyc = cyc + LAT;
      q_read     = bus.read;
      q_addr     = bus.address;
      q_data     = bus.data_in;
      m_ready    = 1'b0;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clock) begin
    if (started) begin
      check("ready", DW'(bus.ready), DW'(m_ready));
      check("done", DW'(bus.done), DW'(m_done));
      if (m_known) check("data_out", bus.data_out, m_data);
`ifdef MEM_RANGE_CHECK_EN
      check("error", DW'(bus.error), DW'(m_err));
`endif
    end
  end

  // Issue one request from the negedge phase; returns edges from acceptance
  // to the edge that raised done (-1 on timeout). Ends at the negedge of the
  // done cycle. Inputs are scrambled after acceptance to show they are ignored.
  task automatic req(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [DW-1:0] data, output int lat);
    int guard;
    lat   = -1;
    guard = 0;
    while (!bus.ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!bus.ready) begin
      timeout("ready_wait");
      return;
    end
    bus.read    = rd;
    bus.write   = wr;
    bus.address = addr;
    bus.data_in = data;
    @(posedge clock);
    #1;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.address = $urandom;
    bus.data_in = rand_line();
    for (int i = 1; i <= 50; i++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) timeout("done_wait");
    @(negedge clock);
  endtask

  initial begin
    int lat;
    logic [DW-1:0] line_b, line_d, line_e;
    bus.read    = 1'b0;
    bus.write   = 1'b0;
    bus.address = '0;
    bus.data_in = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("idle_ready", DW'(bus.ready), DW'(1'b1));
      check("idle_done", DW'(bus.done), DW'(1'b0));
      check("idle_data_out", bus.data_out, '0);
    end

    // Write LINE_A to 0x100; counting the acceptance edge as clock 1, done
    // rises on clock 5.
    req(1'b0, 1'b1, 32'h100, LINE_A, lat);
    check("write_accept_to_done", DW'(lat + 1), DW'(5));
    @(negedge clock);
    check("ready_after_done", DW'(bus.ready), DW'(1'b1));

    // Read from 0x10C: offset bits ignored.
    req(1'b1, 1'b0, 32'h10C, rand_line(), lat);
    check("read_accept_to_done", DW'(lat + 1), DW'(5));
    check("read_0x10c_data", bus.data_out, LINE_A);

    // Read and write together: read wins, write dropped.
    line_b = rand_line();
    req(1'b0, 1'b1, 32'h200, line_b, lat);
    req(1'b1, 1'b1, 32'h200, ~line_b, lat);
    check("both_reads_old", bus.data_out, line_b);
    req(1'b1, 1'b0, 32'h200, '0, lat);
    check("both_write_dropped", bus.data_out, line_b);

    // Reset two cycles into a write of 0x300.
    line_d = rand_line();
    req(1'b0, 1'b1, 32'h300, line_d, lat);
    bus.write   = 1'b1;
    bus.address = 32'h300;
    bus.data_in = ~line_d;
    @(posedge clock);
    #1;
    bus.write = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset_abort_ready", DW'(bus.ready), DW'(1'b1));
    check("reset_abort_done", DW'(bus.done), DW'(1'b0));
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    req(1'b1, 1'b0, 32'h300, '0, lat);
    check("reset_write_discarded", bus.data_out, line_d);

    // Address at DEPTH: wraps to line 0, or rejected with range checking.
    line_e = rand_line();
    req(1'b0, 1'b1, 32'h0, line_e, lat);
    req(1'b1, 1'b0, 32'h0001_0000, '0, lat);
`ifdef MEM_RANGE_CHECK_EN
    check("range_error", DW'(bus.error), DW'(1'b1));
    check("range_data_zero", bus.data_out, '0);
`else
    check("wrap_data", bus.data_out, line_e);
`endif

    // Randomized mixed traffic.
    for (int n = 0; n < 60; n++) begin
      int unsigned kind;
      logic [31:0] addr;
      kind = $urandom_range(0, 2);
      addr = $urandom_range(0, 7) * W + $urandom_range(0, W - 1);
      if ($urandom_range(0, 3) == 0) addr = addr + 32'h1_0000 * $urandom_range(1, 3);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      req(kind != 1, kind != 0, addr, rand_line(), lat);
      check("rand_accept_to_done", DW'(lat), DW'(LAT));
    end

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
